sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
Two-port arbiter and sequencer for the board's 4 x 2Mx8 asynchronous SRAM bank (8 MB total).
- Accepts 32-bit word requests from two requesters: port 0 is the CPU Wishbone bridge, port 1 is the Ethernet/DMA bridge.
- Grants them round-robin and splits each word into byte-wide SRAM cycles with programmable strobe width.
- Sits between the system bus bridges and the top-level SRAM pins; the tristate buffer lives in top.

Parameters:
P_WAIT, 2, strobe-low width in clocks per byte access; legal range 1..15.

Ports:
i_clk  in  1  system clock; all logic on rising edge.
i_reset_n  in  1  asynchronous active-low reset.
i_p0_req  in  1  port 0 request; held high until o_p0_ack.
i_p0_we  in  1  port 0: 1 = write, 0 = read.
i_p0_addr  in  21  port 0 word address (byte address bits 22:2).
i_p0_be  in  4  port 0 byte enables; bit n selects wdata/rdata[8n+7:8n].
i_p0_wdata  in  32  port 0 write data.
o_p0_ack  out  1  port 0 one-cycle completion strobe.
o_p0_rdata  out  32  port 0 read data; valid while o_p0_ack is high.
i_p1_req, i_p1_we, i_p1_addr, i_p1_be, i_p1_wdata, o_p1_ack, o_p1_rdata: same as port 0, for port 1.
o_sram_cs_n  out  4  one-hot-low chip select, decoded from byte address bits 22:21.
o_sram_read_n  out  1  SRAM output enable, active low.
o_sram_write_n  out  1  SRAM write strobe, active low.
o_sram_addr  out  21  SRAM byte address within the chip: {word addr[18:0], byte index[1:0]}.
o_sram_data_oe  out  1  1 = top drives the data bus.
o_sram_data  out  8  write byte.
i_sram_data  in  8  read byte from the pad.

Behaviour:
Reset values:
- cs_n = 4'hF; read_n = 1; write_n = 1; addr = 0; data_oe = 0; data = 0.
- Both acks = 0; both rdata = 0.
- Round-robin pointer = "port 1 last", so port 0 wins the first tie.
- A reset mid-transfer aborts immediately to these values; no ack is issued.

State machine: IDLE, SETUP, STROBE, HOLD, ACK.
- IDLE: sample both reqs.
  - One request pending: grant it.
  - Both pending: grant the port not granted last.
  - On grant: latch we/addr/be/wdata, update the pointer, pick the first byte, go to SETUP.
  - Write with be = 0: go straight to ACK.
- SETUP (1 clk):
  - addr and cs_n driven.
  - On writes: data_oe = 1 and data = the selected byte.
  - Strobes stay high.
- STROBE (P_WAIT clks): read_n or write_n low. Reads sample i_sram_data into the rdata byte lane on the last STROBE clock.
- HOLD (1 clk):
  - Strobes high; addr, cs_n and data_oe unchanged.
  - Then advance to the next byte's SETUP, or to ACK after the last byte.
- ACK (1 clk): the granted port's ack = 1 and rdata is valid; return to IDLE. cs_n = 4'hF and data_oe = 0 in ACK and IDLE.

Byte sequencing:
- Bytes go in ascending order 0..3 (little endian: byte 0 at the lowest address, mapped to bits 7:0).
- Reads always fetch all 4 bytes, ignoring be.
- Writes skip bytes whose be bit is 0; skipping costs zero cycles.

Latency, measured from the IDLE grant edge:
- Full read or write: 4*(P_WAIT+2) cycles, then one ACK cycle. With P_WAIT = 2, ack is high in the 17th cycle.
- A new grant is possible the cycle after ACK, so there is one idle clock between transactions.

Other rules:
- Ack is never asserted to a non-granted port.
- A request deasserted before its ack is a protocol violation; the transfer still completes.
- write_n and read_n are never low in the same cycle.
- data_oe is never 1 during a read transaction.

Decomposition:
Shared package sram_pkg holds:
- state encodings;
- constants C_SRAM_CHIPS = 4, C_SRAM_AW = 21, C_WORD_AW = 21;
- the P_WAIT legal-range check.

One sub-module, sram_rr_arb2: the 2-way round-robin grant with its last-grant pointer. Everything else stays in sram_arbiter.

Test Plan:
- Port 0 read, addr 21'h000010, be = 0, SRAM model returns byte = addr[7:0] -> o_p0_rdata = 32'h43424140, ack in the 17th cycle after grant, cs_n = 4'hE throughout.
- Port 1 write, addr 21'h180000, be = 4'b0101, wdata = 32'hDDCCBBAA -> only bytes 0 and 2 written (AA at 21'h000000, CC at 21'h000002), cs_n = 4'h7, 2*(P_WAIT+2) cycles, then ack.
- Both ports request reads continuously for 4 transactions -> grants alternate 0,1,0,1; each ack is one clock; no ack to the idle port.
- Write with be = 0 on port 0 -> no strobe and no cs_n activity; ack 1 cycle after grant.
- i_reset_n pulled low during the STROBE of byte 2 of a write -> write_n = 1, cs_n = 4'hF, data_oe = 0 asynchronously; no ack after release; next request starts cleanly.
- P_WAIT = 1 and P_WAIT = 15 builds, read of 4 bytes -> ack in cycles 13 and 69 respectively; strobe width equals P_WAIT exactly; read_n and write_n never both low.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the SRAM bank arbiter.
//   state_t        sequencer states (IDLE, SETUP, STROBE, HOLD, ACK)
//   C_SRAM_CHIPS   number of 2Mx8 chips in the bank
//   C_SRAM_AW      byte address width inside one chip
//   C_WORD_AW      requester word address width
//   wait_in_range  legal-range check for the strobe width parameter
//   first_lane     lowest selected byte lane, with a found flag in bit 2
package sram_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    localparam int C_SRAM_CHIPS = 4;
    localparam int C_SRAM_AW    = 21;
    localparam int C_WORD_AW    = 21;

    localparam int C_WAIT_MIN   = 1;
    localparam int C_WAIT_MAX   = 15;
    localparam int C_WAIT_W     = 4;

    function automatic bit wait_in_range(input int w);
        return (w >= C_WAIT_MIN) && (w <= C_WAIT_MAX);
    endfunction

    // Scans from the top lane down so the lowest set lane wins.
    function automatic logic [2:0] first_lane(input logic [3:0] lanes);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (lanes[i]) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: two-way round-robin grant with a last-grant pointer.
//   clk, rst_n   clock and asynchronous active-low reset
//   req          request vector, bit n = port n
//   grant_en     high when the sequencer can accept a new transaction
//   grant_valid  at least one port is requesting
//   grant_port   port that wins this cycle
// After reset the pointer says "port 1 last", so port 0 wins the first tie.
module sram_rr_arb2
    import sram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_valid,
    output logic       grant_port
);

    logic last_port;

    // On a tie the port that was not granted last wins; otherwise the lone requester.
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_port = ~last_port;
        end else begin
            grant_port = req[1];
        end
    end

    // The pointer only moves when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_port <= 1'b1;
        end else if (grant_en && grant_valid) begin
            last_port <= grant_port;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and byte sequencer for a 4 x 2Mx8 async SRAM bank.
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_pN_req/we/addr/be/wdata port N word request (N = 0 CPU bridge, 1 DMA bridge)
//   o_pN_ack, o_pN_rdata      one-cycle completion strobe and read word
//   o_sram_cs_n               one-hot-low chip select from word addr bits 20:19
//   o_sram_read_n/write_n     active-low output enable and write strobe
//   o_sram_addr               byte address within the chip {word[18:0], lane}
//   o_sram_data_oe/data       write data and its pad-driver enable
//   i_sram_data               read byte from the pad
// Each word becomes up to four byte cycles of SETUP, P_WAIT x STROBE, HOLD.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int P_WAIT = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_p0_req,
    input  logic                    i_p0_we,
    input  logic [C_WORD_AW-1:0]    i_p0_addr,
    input  logic [3:0]              i_p0_be,
    input  logic [31:0]             i_p0_wdata,
    output logic                    o_p0_ack,
    output logic [31:0]             o_p0_rdata,
    input  logic                    i_p1_req,
    input  logic                    i_p1_we,
    input  logic [C_WORD_AW-1:0]    i_p1_addr,
    input  logic [3:0]              i_p1_be,
    input  logic [31:0]             i_p1_wdata,
    output logic                    o_p1_ack,
    output logic [31:0]             o_p1_rdata,
    output logic [C_SRAM_CHIPS-1:0] o_sram_cs_n,
    output logic                    o_sram_read_n,
    output logic                    o_sram_write_n,
    output logic [C_SRAM_AW-1:0]    o_sram_addr,
    output logic                    o_sram_data_oe,
    output logic [7:0]              o_sram_data,
    input  logic [7:0]              i_sram_data
);

    if (!wait_in_range(P_WAIT)) begin : g_bad_wait
        $error("sram_arbiter: P_WAIT must be within 1..15");
    end

    localparam logic [C_WAIT_W-1:0] C_LAST_WAIT = C_WAIT_W'(P_WAIT - 1);

    state_t                  state;
    state_t                  state_next;

    logic                    grant_en;
    logic                    grant_valid;
    logic                    grant_port;

    logic                    sel_we;
    logic [C_WORD_AW-1:0]    sel_addr;
    logic [3:0]              sel_be;
    logic [31:0]             sel_wdata;
    logic [3:0]              sel_lanes;
    logic [2:0]              sel_first;

    logic                    cur_port;
    logic                    cur_we;
    logic [C_WORD_AW-1:0]    cur_addr;
    logic [3:0]              cur_lanes;
    logic [31:0]             cur_wdata;
    logic [1:0]              lane;
    logic [C_WAIT_W-1:0]     wait_cnt;
    logic [31:0]             rdata_buf;

    logic [3:0]              above_mask;
    logic [2:0]              next_sel;
    logic                    strobe_last;
    logic [C_SRAM_CHIPS-1:0] chip_sel;

    assign grant_en = (state == S_IDLE);

    sram_rr_arb2 u_arb (
        .clk         (i_clk),
        .rst_n       (i_reset_n),
        .req         ({i_p1_req, i_p0_req}),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // Request of the winning port, and the lanes it will actually touch:
    // reads fetch the whole word, writes only the enabled bytes.
    always_comb begin
        sel_we     = grant_port ? i_p1_we    : i_p0_we;
        sel_addr   = grant_port ? i_p1_addr  : i_p0_addr;
        sel_be     = grant_port ? i_p1_be    : i_p0_be;
        sel_wdata  = grant_port ? i_p1_wdata : i_p0_wdata;
        sel_lanes  = sel_we ? sel_be : 4'hF;
        sel_first  = first_lane(sel_lanes);
        above_mask = 4'b1110 << lane;
        next_sel   = first_lane(cur_lanes & above_mask);
    end

    assign strobe_last = (wait_cnt == C_LAST_WAIT);
    assign chip_sel    = C_SRAM_CHIPS'(1) << cur_addr[C_WORD_AW-1 -: 2];

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. A write with no enabled lane has nothing to strobe and
    // goes straight to ACK; skipped lanes never get a SETUP.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    state_next = sel_first[2] ? S_SETUP : S_ACK;
                end
            end
            S_SETUP:  state_next = S_STROBE;
            S_STROBE: begin
                if (strobe_last) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD:   state_next = next_sel[2] ? S_SETUP : S_ACK;
            S_ACK:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Transaction latches, lane pointer, strobe timer and read assembly.
    // The read byte is captured on the edge that ends the last strobe clock.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cur_port  <= 1'b0;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_lanes <= '0;
            cur_wdata <= '0;
            lane      <= '0;
            wait_cnt  <= '0;
            rdata_buf <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        cur_port  <= grant_port;
                        cur_we    <= sel_we;
                        cur_addr  <= sel_addr;
                        cur_lanes <= sel_lanes;
                        cur_wdata <= sel_wdata;
                        lane      <= sel_first[1:0];
                        wait_cnt  <= '0;
                    end
                end
                S_STROBE: begin
                    if (strobe_last) begin
                        wait_cnt <= '0;
                        if (!cur_we) begin
                            rdata_buf[{lane, 3'b000} +: 8] <= i_sram_data;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    lane <= next_sel[1:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Pin outputs decoded from the state. Chip select and the data driver
    // stay on through SETUP, STROBE and HOLD so the strobe edges are clean.
    always_comb begin
        o_sram_cs_n    = '1;
        o_sram_read_n  = 1'b1;
        o_sram_write_n = 1'b1;
        o_sram_data_oe = 1'b0;
        o_p0_ack       = 1'b0;
        o_p1_ack       = 1'b0;
        case (state)
            S_SETUP, S_HOLD: begin
                o_sram_cs_n    = ~chip_sel;
                o_sram_data_oe = cur_we;
            end
            S_STROBE: begin
                o_sram_cs_n    = ~chip_sel;
                o_sram_data_oe = cur_we;
                o_sram_read_n  = cur_we;
                o_sram_write_n = ~cur_we;
            end
            S_ACK: begin
                o_p0_ack = ~cur_port;
                o_p1_ack = cur_port;
            end
            default: begin
            end
        endcase
    end

    assign o_sram_addr = {cur_addr[C_SRAM_AW-3:0], lane};
    assign o_sram_data = cur_we ? cur_wdata[{lane, 3'b000} +: 8] : 8'h00;
    assign o_p0_rdata  = rdata_buf;
    assign o_p1_rdata  = rdata_buf;

endmodule
